// File: rtl/axi_burst_splitter_if.sv
// axi_burst_splitter_if: request and burst-command signals of the burst splitter
interface axi_burst_splitter_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int CNT_W  = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [CNT_W-1:0]  req_beats;
    logic              req_write;
    logic [ID_W-1:0]   req_id;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [3:0]        cmd_len;
    logic [2:0]        cmd_size;
    logic [1:0]        cmd_burst;
    logic [ID_W-1:0]   cmd_id;
    logic              cmd_last;
    logic              busy;
    logic              err;

    modport slave (
        input  req_valid, req_addr, req_beats, req_write, req_id, cmd_ready,
        output req_ready, cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_size,
               cmd_burst, cmd_id, cmd_last, busy, err
    );

    modport master (
        output req_valid, req_addr, req_beats, req_write, req_id, cmd_ready,
        input  req_ready, cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_size,
               cmd_burst, cmd_id, cmd_last, busy, err
    );
endinterface

// File: rtl/axi_burst_splitter.sv
// axi_burst_splitter: splits a linear word transfer into AXI3 INCR bursts (<=16 beats, no 4 KB crossing); BURST_ERR_CHECK_EN rejects zero-length or misaligned requests
module axi_burst_splitter #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int CNT_W  = 12
) (
    input logic                clk,
    input logic                reset,
    axi_burst_splitter_if.slave bus
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr, w_src_addr;
    logic [CNT_W:0]    r_rem, w_src_rem;
    logic [3:0]        r_len;
    logic              r_last, r_write, r_err;
    logic [ID_W-1:0]   r_id;
    logic [12:0]       w_page;
    logic [4:0]        w_cap, w_n, w_new_n;
    logic              w_req_hs, w_bad, w_load, w_adv;

`ifdef BURST_ERR_CHECK_EN
    assign w_bad = bus.req_beats == '0 || bus.req_addr[1:0] != 2'b00;
`else
    assign w_bad = 1'b0;
`endif

    // next state plus the burst that would be loaded: from the request in IDLE, from the advanced pointer in ISSUE
    always_comb begin
        w_req_hs   = bus.req_valid && bus.req_ready;
        w_load     = w_req_hs && !w_bad;
        w_adv      = r_state == ISSUE && bus.cmd_ready && !r_last;
        w_next     = r_state == IDLE ? (w_load ? ISSUE : IDLE) : (bus.cmd_ready && r_last ? IDLE : ISSUE);
        w_n        = {1'b0, r_len} + 5'd1;
        w_src_addr = r_state == IDLE ? bus.req_addr & ~ADDR_W'(3) : r_addr + ADDR_W'({w_n, 2'b00});
        w_src_rem  = r_state == IDLE ? (bus.req_beats == '0 ? (CNT_W+1)'(1) << CNT_W : {1'b0, bus.req_beats})
                                     : r_rem - (CNT_W+1)'(w_n);
        w_page     = (13'd4096 - {1'b0, w_src_addr[11:0]}) >> 2;
        w_cap      = w_page < 13'd16 ? w_page[4:0] : 5'd16;
        w_new_n    = w_src_rem < (CNT_W+1)'(w_cap) ? w_src_rem[4:0] : w_cap;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // registered command fields, only updated on a new request or an accepted non-final burst
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_rem   <= '0;
            r_len   <= '0;
            r_last  <= 1'b0;
            r_write <= 1'b0;
            r_id    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_req_hs && w_bad;
            if (w_load || w_adv) begin
                r_addr <= w_src_addr;
                r_rem  <= w_src_rem;
                r_len  <= 4'(w_new_n - 5'd1);
                r_last <= (CNT_W+1)'(w_new_n) == w_src_rem;
            end
            if (w_load) begin
                r_id    <= bus.req_id;
                r_write <= bus.req_write;
            end
        end
    end

    assign bus.req_ready = !reset && r_state == IDLE;
    assign bus.cmd_valid = r_state == ISSUE;
    assign bus.busy      = r_state == ISSUE;
    assign bus.cmd_addr  = r_addr;
    assign bus.cmd_len   = r_len;
    assign bus.cmd_last  = r_last;
    assign bus.cmd_id    = r_id;
    assign bus.cmd_write = r_write;
    assign bus.cmd_size  = 3'b010;
    assign bus.cmd_burst = 2'b01;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_axi_burst_splitter.sv
// tb_axi_burst_splitter: randomized and directed checks of the burst splitter against a burst-list model
module tb_axi_burst_splitter;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int CNT_W  = 12;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
        logic        write;
        logic        last;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    cmd_t exp_q[$];
    cmd_t obs;

    axi_burst_splitter_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .CNT_W(CNT_W)) bus();
    axi_burst_splitter #(.ADDR_W(ADDR_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    assign obs = {bus.cmd_addr, bus.cmd_len, bus.cmd_size, bus.cmd_burst, bus.cmd_id, bus.cmd_write, bus.cmd_last};

    // expected burst list: greedy chunks limited by words left, 16 beats and bytes left in the 4 KB page
    task automatic build(input logic [31:0] addr, input int beats, input logic w, input logic [3:0] id);
        logic [31:0] a;
        int r, n, room;
        a = addr & 32'hFFFF_FFFC;
        r = beats == 0 ? 4096 : beats;
        exp_q.delete();
        while (r > 0) begin
            room = (4096 - int'(a % 4096)) / 4;
            n = r < 16 ? r : 16;
            if (room < n) n = room;
            exp_q.push_back('{a, 4'(n - 1), 3'b010, 2'b01, id, w, n == r});
            a = a + 32'(4 * n);
            r -= n;
        end
    endtask

    // mode 0: cmd_ready held high, 1: random back-pressure, 2: five stall cycles on the second burst
    task automatic do_req(input logic [31:0] addr, input int beats, input logic w, input logic [3:0] id, input int mode);
        int k, cyc, stall;
        k = 0; cyc = 0; stall = 0;
        build(addr, beats, w, id);
        bus.req_addr  = addr;
        bus.req_beats = 12'(beats);
        bus.req_write = w;
        bus.req_id    = id;
        bus.req_valid = 1'b1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_idle got %b want 1", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++;
        if (bus.cmd_valid !== 1'b1 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL latency cmd_valid=%b busy=%b req_ready=%b want 1 1 0", bus.cmd_valid, bus.busy, bus.req_ready);
        end
        while (k < exp_q.size() && cyc < 20000) begin
            checks++;
            if (bus.cmd_valid !== 1'b1 || obs !== exp_q[k]) begin
                errors++;
                $display("FAIL cmd[%0d] valid=%b got %h want %h", k, bus.cmd_valid, obs, exp_q[k]);
            end
            bus.cmd_ready = mode == 0 ? 1'b1 : mode == 1 ? $urandom_range(0, 3) != 0 : !(k == 1 && stall < 5);
            if (mode == 2 && k == 1 && stall < 5) stall++;
            @(posedge clk); #1;
            if (bus.cmd_ready) k++;
            cyc++;
        end
        bus.cmd_ready = 1'b0;
        checks++;
        if (k != exp_q.size() || bus.cmd_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done bursts=%0d/%0d cmd_valid=%b req_ready=%b busy=%b want 0 1 0",
                     k, exp_q.size(), bus.cmd_valid, bus.req_ready, bus.busy);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || obs !== cmd_t'({32'h0, 4'h0, 3'b010, 2'b01, 4'h0, 1'b0, 1'b0})
            || bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset rdy=%b vld=%b busy=%b err=%b cmd=%h", bus.req_ready, bus.cmd_valid, bus.busy, bus.err, obs);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset req_ready=%b cmd_valid=%b want 1 0", bus.req_ready, bus.cmd_valid);
        end
    endtask

    task automatic test_directed();
        do_req(32'h1000, 16, 1'b1, 4'd3, 0);
        do_req(32'h0FF0, 20, 1'b1, 4'd7, 0);
        do_req(32'h2000, 40, 1'b0, 4'd1, 0);
        do_req(32'h2000, 40, 1'b0, 4'd2, 2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            do_req($urandom, $urandom_range(1, 70), 1'($urandom), 4'($urandom), i % 2);
    endtask

    task automatic test_reset_mid();
        bus.req_addr  = 32'h2000;
        bus.req_beats = 12'd40;
        bus.req_write = 1'b1;
        bus.req_id    = 4'd9;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.cmd_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_ready = 1'b0;
        checks++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd_addr !== 32'h2040) begin
            errors++;
            $display("FAIL mid_second_burst cmd_valid=%b addr=%h want 1 00002040", bus.cmd_valid, bus.cmd_addr);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b0 || bus.cmd_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset cmd_valid=%b busy=%b req_ready=%b addr=%h", bus.cmd_valid, bus.busy, bus.req_ready, bus.cmd_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_req(32'h0, 1, 1'b0, 4'd4, 0);
    endtask

    task automatic test_zero_beats();
`ifdef BURST_ERR_CHECK_EN
        for (int i = 0; i < 2; i++) begin
            bus.req_addr  = i == 0 ? 32'h0 : 32'h1002;
            bus.req_beats = i == 0 ? 12'd0 : 12'd4;
            bus.req_valid = 1'b1;
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            checks++;
            if (bus.err !== 1'b1 || bus.cmd_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL err_pulse[%0d] err=%b cmd_valid=%b req_ready=%b want 1 0 1", i, bus.err, bus.cmd_valid, bus.req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.err !== 1'b0 || bus.cmd_valid !== 1'b0) begin
                errors++;
                $display("FAIL err_clear[%0d] err=%b cmd_valid=%b want 0 0", i, bus.err, bus.cmd_valid);
            end
        end
`else
        do_req(32'h0, 0, 1'b1, 4'd6, 0);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_tied got %b want 0", bus.err);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] a;
        int b;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            if ($urandom_range(0, 2) == 0) a[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
`ifdef BURST_ERR_CHECK_EN
            a[1:0] = 2'b00;
            b = $urandom_range(1, 200);
`else
            b = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 200);
`endif
            do_req(a, b, 1'($urandom), 4'($urandom), 1);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_beats = '0;
        bus.req_write = 1'b0;
        bus.req_id    = '0;
        bus.cmd_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_zero_beats();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
